// File: rtl/button_debounce_if.sv
// Connects the debouncer to the button side and to the edge-detect stage.
// glitch_count and the GLITCH_W parameter exist only when DEBOUNCE_GLITCH_CNT_EN is defined.
interface button_debounce_if
`ifdef DEBOUNCE_GLITCH_CNT_EN
    #(parameter int GLITCH_W = 8)
`endif
    ;
    logic btn_raw;
    logic btn_level;
    logic btn_busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_count;

    modport master (output btn_raw, input btn_level, btn_busy, glitch_count);
    modport slave  (input btn_raw, output btn_level, btn_busy, glitch_count);
`else
    modport master (output btn_raw, input btn_level, btn_busy);
    modport slave  (input btn_raw, output btn_level, btn_busy);
`endif
endinterface

// File: rtl/button_debounce.sv
// Pushbutton debouncer: a synchroniser chain followed by a 4-state stability FSM with a hold-off counter.
// Optional aborted-transition counter enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module button_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , parameter int GLITCH_W    = 8
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    button_debounce_if.slave  bus
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   busy_q, busy_d;

    // NOTE: every flop here, including the synchroniser chain, takes its reset value;
    // a power-up X on the chain would otherwise reach the FSM as a phantom edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees
    // pre-edge values regardless of the order in which the processes run.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LO: if (s) begin
                state_d = WAIT_HI;
                cnt_d   = '0;
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            STABLE_HI: if (!s) begin
                state_d = WAIT_LO;
                cnt_d   = '0;
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
        // Outputs are decoded from the next state so they register on the same edge as the state.
        level_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);
        busy_d  = (state_d == WAIT_HI)   || (state_d == WAIT_LO);
    end

    assign bus.btn_level = level_q;
    assign bus.btn_busy  = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                abort;
    logic [GLITCH_W-1:0] glitch_q;

    assign abort = ((state_q == WAIT_HI) && !s) || ((state_q == WAIT_LO) && s);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            glitch_q <= '0;
        end else if (abort && (glitch_q != '1)) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    assign bus.glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed vector tables on a 2-stage/4-cycle instance plus
// randomized bouncing on both instances against a run-length reference model.
module tb_button_debounce;

    localparam int SYNC0   = 2;
    localparam int STABLE0 = 4;
    localparam int SYNC1   = 3;
    localparam int STABLE1 = 1;
    localparam int GW      = 2;
    localparam int GMAX    = (1 << GW) - 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic raw     = 1'b0;

    always #5 clk = ~clk;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    button_debounce_if #(.GLITCH_W(GW)) if0 ();
    button_debounce_if #(.GLITCH_W(GW)) if1 ();
`else
    button_debounce_if if0 ();
    button_debounce_if if1 ();
`endif

    assign if0.btn_raw = raw;
    assign if1.btn_raw = raw;

    button_debounce #(
        .SYNC_STAGES   (SYNC0),
        .STABLE_CYCLES (STABLE0),
        .CNT_WIDTH     (4)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .GLITCH_W    (GW)
`endif
    ) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if0.slave)
    );

    button_debounce #(
        .SYNC_STAGES   (SYNC1),
        .STABLE_CYCLES (STABLE1),
        .CNT_WIDTH     (2)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .GLITCH_W    (GW)
`endif
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if1.slave)
    );

    typedef struct {
        logic rst_n;
        logic raw;
        logic lvl;
        logic busy;
        int   glitch;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk0  = 1'b0;

    // Reference model: the synchronised input is the raw sample from SYNC edges ago; the level
    // flips once the synchronised input has disagreed with it on STABLE+1 consecutive edges.
    logic hist [4];
    logic m_lvl    [2];
    int   m_streak [2];
    int   m_gl     [2];
    int   m_sync   [2] = '{SYNC0, SYNC1};
    int   m_stab   [2] = '{STABLE0, STABLE1};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic b);
        if (!r) begin
            for (int k = 0; k < 4; k++) hist[k] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_lvl[i]    = 1'b0;
                m_streak[i] = 0;
                m_gl[i]     = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (hist[m_sync[i]-1] != m_lvl[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == m_stab[i] + 1) begin
                        m_lvl[i]    = ~m_lvl[i];
                        m_streak[i] = 0;
                    end
                end else begin
                    if (m_streak[i] > 0 && m_gl[i] < GMAX) m_gl[i]++;
                    m_streak[i] = 0;
                end
            end
            for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = b;
        end
    endtask

    task automatic step(input logic r, input logic b);
        reset_n = r;
        raw     = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
        check("dut1_level", int'(if1.btn_level), int'(m_lvl[1]));
        check("dut1_busy",  int'(if1.btn_busy),  int'(m_streak[1] > 0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("dut1_glitch", int'(if1.glitch_count), m_gl[1]);
`endif
        if (chk0) begin
            check("dut0_level", int'(if0.btn_level), int'(m_lvl[0]));
            check("dut0_busy",  int'(if0.btn_busy),  int'(m_streak[0] > 0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
            check("dut0_glitch", int'(if0.glitch_count), m_gl[0]);
`endif
        end
    endtask

    task automatic add(input logic r, input logic b, input logic l, input logic bs, input int g);
        vec_t v;
        v.rst_n  = r;
        v.raw    = b;
        v.lvl    = l;
        v.busy   = bs;
        v.glitch = g;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].raw);
            check({name, "_level"}, int'(if0.btn_level), int'(tbl[i].lvl));
            check({name, "_busy"},  int'(if0.btn_busy),  int'(tbl[i].busy));
`ifdef DEBOUNCE_GLITCH_CNT_EN
            check({name, "_glitch"}, int'(if0.glitch_count), tbl[i].glitch);
`endif
        end
        tbl.delete();
    endtask

    initial begin
        // Reset then idle, followed by a clean press: busy after edge 2, level after edge 6.
        add(0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) add(1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) add(1, 1, k >= 6, (k >= 2) && (k <= 5), 0);
        run_table("press");

        // Three-clock pulse: busy pulses, level stays low, one glitch.
        add(0, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) add(1, k < 3, 0, (k >= 2) && (k <= 4), (k >= 5) ? 1 : 0);
        run_table("short");

        // Bounce 1,0,1,1,0,1 then held; then a 2-clock low dip; then a clean release.
        begin
            logic bnc [6] = '{1, 0, 1, 1, 0, 1};
            logic bsy [13] = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0};
            add(0, 0, 0, 0, 0);
            for (int k = 0; k < 13; k++)
                add(1, (k < 6) ? bnc[k] : 1'b1, k >= 11, bsy[k], (k >= 6) ? 2 : ((k >= 3) ? 1 : 0));
            for (int j = 0; j < 8; j++) add(1, j >= 2, 1, (j == 2) || (j == 3), (j >= 4) ? 3 : 2);
            for (int m = 0; m < 8; m++) add(1, 0, m < 6, (m >= 2) && (m <= 5), 3);
        end
        run_table("bounce");

        // Reset while in WAIT_HI with the button held, then full re-qualification.
        add(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(1, 1, 0, k >= 2, 0);
        add(0, 1, 0, 0, 0);
        for (int r = 0; r < 8; r++) add(1, 1, r >= 6, (r >= 2) && (r <= 5), 0);
        run_table("midrst");

        // Five forced aborts: the 2-bit glitch counter saturates at 3.
        add(0, 0, 0, 0, 0);
        for (int k = 0; k < 14; k++)
            add(1, (k < 10) && (k % 2 == 0), 0, (k >= 2) && (k <= 10) && (k % 2 == 0),
                (k < 3) ? 0 : (((k - 1) / 2 > GMAX) ? GMAX : (k - 1) / 2));
        run_table("sat");

        // Randomized bouncing with occasional reset, both instances against the model.
        chk0 = 1'b1;
        step(0, 0);
        for (int n = 0; n < 300; n++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(1, 5));
            for (int t = 0; t < len; t++)
                step(($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
